fetch_exec_controller: RTL and testbench
========================================

Name: fetch_exec_controller

Overview:
- Moore-style sequencer for the 16-bit accumulator CPU.
- Drives the instruction register load strobe, PC, memory and accumulator control lines through the eight-phase fetch/execute cycle.
- Decodes the 3-bit opcode held in the instruction register.
- Stalls on a memory ready handshake and traps to a halted state on HLT or on a memory timeout.

Parameters:
- MEM_TIMEOUT, 15, maximum consecutive stall cycles waiting on mem_rdy before bus_err (1..255).
- CNT_W, 8, width of the stall counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; the block is in reset while rst is 0.
- opcode  in  3  current opcode from the instruction register; valid from OP_ADDR onward.
- zero  in  1  accumulator-is-zero flag from the ALU.
- mem_rdy  in  1  memory ready; read data or write completion is valid this cycle.
- sel  out  1  address mux select: 1 = PC, 0 = IR address field.
- rd  out  1  memory read enable.
- wr  out  1  memory write enable.
- ldir  out  1  instruction register load strobe.
- ld_ac  out  1  accumulator load.
- inc_pc  out  1  PC increment.
- ld_pc  out  1  PC load from IR address field.
- data_e  out  1  accumulator drives the data bus.
- halt  out  1  CPU halted (HLT or bus error).
- bus_err  out  1  sticky memory-timeout flag.

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- State register is 4 bits. States: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED.
- Outputs are decoded from the state register and opcode/zero only; there are no mem_rdy-to-output combinational paths.
- Reset (rst=0): state=INST_ADDR, stall counter=0, bus_err=0. Resulting outputs: sel=1, all others 0. Reset mid-instruction aborts that instruction with no write issued after reset release.
- Per-state outputs and transitions:
  - INST_ADDR: sel. Next state INST_FETCH.
  - INST_FETCH: sel, rd. Stays while mem_rdy=0; goes to INST_LOAD when mem_rdy=1.
  - INST_LOAD: sel, rd, ldir. The IR captures on the edge leaving this state. Next state IDLE.
  - IDLE: no outputs. Gives the IR one cycle to settle. Next state OP_ADDR.
  - OP_ADDR: inc_pc. If opcode=HLT, go to HALTED with inc_pc still asserted this cycle; otherwise go to OP_FETCH.
  - OP_FETCH: rd if ALUOP. Stalls while ALUOP and mem_rdy=0; a non-ALUOP opcode never stalls. Next state ALU_OP.
  - ALU_OP: rd and ld_ac if ALUOP; inc_pc if SKZ and zero=1; ld_pc if JMP; data_e if STO. Next state STORE.
  - STORE: wr and data_e if STO; ld_pc if JMP. STO waits in STORE until mem_rdy=1. Next state INST_ADDR.
  - HALTED: halt=1, all other outputs 0. Stays until reset.
- Nominal latency is 8 cycles per instruction. Each cycle with mem_rdy low during a wait state adds one cycle.
- Stall counter:
  - Increments on each cycle spent waiting in a wait state (INST_FETCH, OP_FETCH, STORE with STO).
  - Clears on any state change.
  - When it reaches MEM_TIMEOUT with mem_rdy still 0: set bus_err, go to HALTED, and deassert rd/wr from the next cycle.
  - mem_rdy=1 on the same cycle as the timeout has priority: the access completes and no error is raised.
- Simultaneous inc_pc and ld_pc never occur.
- A skipped SKZ increments the PC exactly once beyond the OP_ADDR increment.
- An unknown or X opcode is treated as HLT (defensive default).

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined, adds two ports: input step and output waiting.
  - In INST_ADDR the controller holds (waiting=1) until it sees a rising edge of step, detected through a 2-flop synchroniser plus an edge register.
  - It then runs exactly one instruction.
  - A step edge that arrives mid-instruction is latched and consumed at the next INST_ADDR.
  - The synchroniser and edge registers reset to 0.
- When undefined, the ports are absent and the controller free-runs.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_HLT..OP_JMP);
  - state encoding constants;
  - the ALUOP decode function, shared with the ALU.
- One natural sub-module, ctrl_decode: purely combinational state+opcode+zero -> control-word decode, kept separate so the ALU team can reuse the table.
- Sequencing, stall counter and step logic stay in the top block.

Test Plan:
- Reset then LDA with mem_rdy tied 1 -> ldir pulses on cycle 3 after reset release; rd+ld_ac in ALU_OP; back in INST_ADDR at cycle 8.
- STO with mem_rdy low 3 cycles in STORE -> wr+data_e held for 4 cycles; single INST_ADDR follows; no ld_ac.
- SKZ with zero=1, then with zero=0 -> inc_pc pulses 2 vs 1 times per instruction; JMP -> ld_pc in ALU_OP and STORE, inc_pc only in OP_ADDR.
- mem_rdy held 0 in INST_FETCH with MEM_TIMEOUT=15 -> bus_err=1 and halt=1 after exactly 15 stall cycles; rd low afterwards; rst=0 clears both.
- HLT opcode -> halt=1 from the cycle after OP_ADDR and persists 100 cycles; rst asserted mid-OP_FETCH of an ADD -> immediate sel=1, others 0.
- With SINGLE_STEP_EN: two step pulses 50 cycles apart -> exactly two instructions executed; waiting=1 between them.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU:
// opcodes, sequencer states, control word, ALUOP decode.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ldir;
    logic ld_ac;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic halt;
  } ctrl_t;

  function automatic logic is_aluop(
    input logic [2:0] op
  );
    case (op)
      OP_ADD, OP_AND,
      OP_XOR, OP_LDA: is_aluop = 1'b1;
      default:        is_aluop = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode: state + opcode + zero -> ctrl.
// Ports: state, opcode, zero in; ctrl (sel..halt) out.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t      state,
  input  logic [2:0]  opcode,
  input  logic        zero,
  output ctrl_t       ctrl
);

  logic aluop;
  logic is_skz;
  logic is_sto;
  logic is_jmp;

  always_comb begin
    aluop  = is_aluop(opcode);
    is_skz = (opcode == OP_SKZ);
    is_sto = (opcode == OP_STO);
    is_jmp = (opcode == OP_JMP);
    ctrl   = '0;
    unique case (1'b1)
      state == S_INST_ADDR: begin
        ctrl.sel = 1'b1;
      end
      state == S_INST_FETCH: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      state == S_INST_LOAD: begin
        ctrl.sel  = 1'b1;
        ctrl.rd   = 1'b1;
        ctrl.ldir = 1'b1;
      end
      state == S_IDLE: begin
        ctrl = '0;
      end
      state == S_OP_ADDR: begin
        ctrl.inc_pc = 1'b1;
      end
      state == S_OP_FETCH: begin
        ctrl.rd = aluop;
      end
      state == S_ALU_OP: begin
        ctrl.rd     = aluop;
        ctrl.ld_ac  = aluop;
        ctrl.inc_pc = is_skz & zero;
        ctrl.ld_pc  = is_jmp;
        ctrl.data_e = is_sto;
      end
      state == S_STORE: begin
        ctrl.wr     = is_sto;
        ctrl.data_e = is_sto;
        ctrl.ld_pc  = is_jmp;
      end
      state == S_HALTED: begin
        ctrl.halt = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_exec_controller.sv
// Eight-phase fetch/execute sequencer with mem_rdy stalls, timeout trap.
// Ports: clk, rst (async low), opcode, zero, mem_rdy in; sel, rd, wr,
// ldir, ld_ac, inc_pc, ld_pc, data_e, halt, bus_err out.
// Macro SINGLE_STEP_EN adds step (in) and waiting (out).
module fetch_exec_controller
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_rdy,
`ifdef SINGLE_STEP_EN
  input  logic       step,
  output logic       waiting,
`endif
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ldir,
  output logic       ld_ac,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       halt,
  output logic       bus_err
);

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic              bus_err_n;
  logic              aluop;
  logic              wait_st;
  logic              stall;
  logic              timeout;
  logic              go;
  ctrl_t             ctrl;

`ifdef SINGLE_STEP_EN
  logic s1;
  logic s2;
  logic s3;
  logic pend;
  logic consume;

  assign consume = (state == S_INST_ADDR) & pend;
  assign go      = pend;
  assign waiting = (state == S_INST_ADDR) & ~pend;

  // A step edge seen while an instruction runs stays pending
  // until the next INST_ADDR consumes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      pend <= 1'b0;
    end else begin
      s1   <= step;
      s2   <= s1;
      s3   <= s2;
      pend <= (s2 & ~s3) | (pend & ~consume);
    end
  end
`else
  assign go = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_INST_ADDR;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bus_err <= bus_err_n;
    end
  end

  always_comb begin
    aluop   = is_aluop(opcode);
    wait_st = (state == S_INST_FETCH)
            | ((state == S_OP_FETCH) & aluop)
            | ((state == S_STORE) & (opcode == OP_STO));
    stall   = wait_st & ~mem_rdy;
    // The stall cycle that would bring the count to MEM_TIMEOUT traps;
    // mem_rdy high on that cycle is not a stall, so it completes.
    timeout = stall & (cnt == CNT_W'(MEM_TIMEOUT - 1));
    state_n = state;
    case (state)
      S_INST_ADDR:  state_n = go ? S_INST_FETCH : S_INST_ADDR;
      S_INST_FETCH: state_n = S_INST_LOAD;
      S_INST_LOAD:  state_n = S_IDLE;
      S_IDLE:       state_n = S_OP_ADDR;
      S_OP_ADDR: begin
        // Anything not a known non-HLT opcode (incl. X) halts.
        case (opcode)
          OP_SKZ, OP_ADD, OP_AND, OP_XOR,
          OP_LDA, OP_STO, OP_JMP: state_n = S_OP_FETCH;
          default:                state_n = S_HALTED;
        endcase
      end
      S_OP_FETCH:   state_n = S_ALU_OP;
      S_ALU_OP:     state_n = S_STORE;
      S_STORE:      state_n = S_INST_ADDR;
      S_HALTED:     state_n = S_HALTED;
      default:      state_n = S_INST_ADDR;
    endcase
    if (stall) begin
      state_n = timeout ? S_HALTED : state;
    end
    cnt_n = cnt;
    if (state_n != state) begin
      cnt_n = '0;
    end else if (stall) begin
      cnt_n = cnt + 1'b1;
    end
    bus_err_n = bus_err | timeout;
  end

  ctrl_decode u_dec (
    .state  (state),
    .opcode (opcode),
    .zero   (zero),
    .ctrl   (ctrl)
  );

  assign sel    = ctrl.sel;
  assign rd     = ctrl.rd;
  assign wr     = ctrl.wr;
  assign ldir   = ctrl.ldir;
  assign ld_ac  = ctrl.ld_ac;
  assign inc_pc = ctrl.inc_pc;
  assign ld_pc  = ctrl.ld_pc;
  assign data_e = ctrl.data_e;
  assign halt   = ctrl.halt;

endmodule

// File: tb/tb_fetch_exec_controller.sv
// Directed self-checking bench for fetch_exec_controller.
// Output vector order: sel rd wr ldir ld_ac inc_pc ld_pc data_e halt bus_err.
module tb_fetch_exec_controller;
  import cpu_pkg::*;

  localparam logic [9:0] E_IA   = 10'b1000000000;
  localparam logic [9:0] E_F    = 10'b1100000000;
  localparam logic [9:0] E_L    = 10'b1101000000;
  localparam logic [9:0] E_ID   = 10'b0000000000;
  localparam logic [9:0] E_OA   = 10'b0000010000;
  localparam logic [9:0] E_RD   = 10'b0100000000;
  localparam logic [9:0] E_ALU  = 10'b0100100000;
  localparam logic [9:0] E_DE   = 10'b0000000100;
  localparam logic [9:0] E_ST   = 10'b0010000100;
  localparam logic [9:0] E_LDPC = 10'b0000001000;
  localparam logic [9:0] E_HALT = 10'b0000000010;
  localparam logic [9:0] E_ERR  = 10'b0000000011;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rdy;
  logic       sel, rd, wr, ldir, ld_ac;
  logic       inc_pc, ld_pc, data_e, halt, bus_err;
`ifdef SINGLE_STEP_EN
  logic       step;
  logic       waiting;
`endif
  logic [9:0] ov;
  int         tests;
  int         fails;

  assign ov = {sel, rd, wr, ldir, ld_ac,
               inc_pc, ld_pc, data_e, halt, bus_err};

  fetch_exec_controller #(
    .MEM_TIMEOUT (15),
    .CNT_W       (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rdy (mem_rdy),
`ifdef SINGLE_STEP_EN
    .step    (step),
    .waiting (waiting),
`endif
    .sel     (sel),
    .rd      (rd),
    .wr      (wr),
    .ldir    (ldir),
    .ld_ac   (ld_ac),
    .inc_pc  (inc_pc),
    .ld_pc   (ld_pc),
    .data_e  (data_e),
    .halt    (halt),
    .bus_err (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    #1;
    tests++;
    if (ov !== E_IA) begin
      fails++;
      $display("FAIL reset: got %b want %b", ov, E_IA);
    end
  endtask

  task automatic test_lda();
    logic [9:0] ev [9];
    ev = '{E_IA, E_F, E_L, E_ID, E_OA, E_RD, E_ALU, E_ID, E_IA};
    do_reset();
    opcode  = OP_LDA;
    mem_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      tests++;
      if (ov !== ev[i]) begin
        fails++;
        $display("FAIL lda c%0d: got %b want %b", i, ov, ev[i]);
      end
      if (i < 8) tick();
    end
  endtask

  task automatic test_sto_stall();
    logic [9:0] ev [13];
    ev = '{E_IA, E_F, E_L, E_ID, E_OA, E_ID, E_DE,
           E_ST, E_ST, E_ST, E_ST, E_IA, E_F};
    do_reset();
    opcode = OP_STO;
    for (int i = 0; i < 13; i++) begin
      mem_rdy = !(i >= 7 && i <= 9);
      #1;
      tests++;
      if (ov !== ev[i]) begin
        fails++;
        $display("FAIL sto c%0d: got %b want %b", i, ov, ev[i]);
      end
      if (i < 12) tick();
    end
  endtask

  task automatic test_skz_jmp();
    logic [9:0] ev [3][9];
    logic [2:0] op  [3];
    logic       z   [3];
    int         pcs [3];
    int         n;
    ev[0] = '{E_IA, E_F, E_L, E_ID, E_OA, E_ID, E_OA, E_ID, E_IA};
    ev[1] = '{E_IA, E_F, E_L, E_ID, E_OA, E_ID, E_ID, E_ID, E_IA};
    ev[2] = '{E_IA, E_F, E_L, E_ID, E_OA, E_ID,
              E_LDPC, E_LDPC, E_IA};
    op  = '{OP_SKZ, OP_SKZ, OP_JMP};
    z   = '{1'b1, 1'b0, 1'b1};
    pcs = '{2, 1, 1};
    mem_rdy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      opcode = op[t];
      zero   = z[t];
      n      = 0;
      for (int i = 0; i < 9; i++) begin
        #1;
        if (i < 8 && inc_pc === 1'b1) n++;
        tests++;
        if (ov !== ev[t][i]) begin
          fails++;
          $display("FAIL skzjmp t%0d c%0d: got %b want %b",
                   t, i, ov, ev[t][i]);
        end
        if (i < 8) tick();
      end
      tests++;
      if (n != pcs[t]) begin
        fails++;
        $display("FAIL inc_pc_count t%0d: got %0d want %0d",
                 t, n, pcs[t]);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    do_reset();
    opcode  = OP_LDA;
    mem_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      e = (i == 0) ? E_IA : (i <= 15) ? E_F : E_ERR;
      #1;
      tests++;
      if (ov !== e) begin
        fails++;
        $display("FAIL timeout c%0d: got %b want %b", i, ov, e);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ov !== E_IA) begin
      fails++;
      $display("FAIL timeout_clear: got %b want %b", ov, E_IA);
    end
    rst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      mem_rdy = (i == 15);
      e = (i == 0) ? E_IA : (i <= 15) ? E_F :
          (i == 16) ? E_L : E_ID;
      #1;
      tests++;
      if (ov !== e) begin
        fails++;
        $display("FAIL rdy_prio c%0d: got %b want %b", i, ov, e);
      end
      tick();
    end
  endtask

  task automatic test_hlt();
    logic [9:0] e;
    do_reset();
    opcode  = OP_HLT;
    mem_rdy = 1'b1;
    for (int i = 0; i < 105; i++) begin
      e = (i == 0) ? E_IA : (i == 1) ? E_F : (i == 2) ? E_L :
          (i == 3) ? E_ID : (i == 4) ? E_OA : E_HALT;
      #1;
      tests++;
      if (ov !== e) begin
        fails++;
        $display("FAIL hlt c%0d: got %b want %b", i, ov, e);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int nwr;
    do_reset();
    opcode  = OP_ADD;
    mem_rdy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (ov !== E_RD) begin
        fails++;
        $display("FAIL add_stall c%0d: got %b want %b", i, ov, E_RD);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ov !== E_IA) begin
      fails++;
      $display("FAIL rst_mid_add: got %b want %b", ov, E_IA);
    end
    tick();
    rst     = 1'b1;
    opcode  = OP_STO;
    mem_rdy = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    mem_rdy = 1'b0;
    #1;
    tests++;
    if (ov !== E_ST) begin
      fails++;
      $display("FAIL sto_in_store: got %b want %b", ov, E_ST);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ov !== E_IA) begin
      fails++;
      $display("FAIL rst_mid_sto: got %b want %b", ov, E_IA);
    end
    tick();
    rst     = 1'b1;
    opcode  = OP_LDA;
    mem_rdy = 1'b1;
    nwr     = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (wr !== 1'b0) nwr++;
      tick();
    end
    tests++;
    if (nwr != 0) begin
      fails++;
      $display("FAIL no_wr_after_rst: got %0d want 0", nwr);
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    int nld;
    int lim;
    do_reset();
    opcode  = OP_LDA;
    mem_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (waiting !== 1'b1 || ov !== E_IA) begin
        fails++;
        $display("FAIL step_hold c%0d: got %b/%b want 1/%b",
                 i, waiting, ov, E_IA);
      end
      tick();
    end
    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      lim  = 0;
      tick();
      tick();
      tick();
      step = 1'b0;
      while (waiting === 1'b1 && lim < 8) begin
        tick();
        lim++;
      end
      tests++;
      if (waiting !== 1'b0) begin
        fails++;
        $display("FAIL step_start p%0d: got %b want 0", p, waiting);
      end
      nld = 0;
      for (int i = 0; i < 50; i++) begin
        if (ldir === 1'b1) nld++;
        tick();
      end
      tests++;
      if (nld != 1 || waiting !== 1'b1) begin
        fails++;
        $display("FAIL step_run p%0d: got %0d/%b want 1/1",
                 p, nld, waiting);
      end
    end
  endtask
`endif

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b0;
    opcode  = OP_LDA;
    zero    = 1'b0;
    mem_rdy = 1'b1;
`ifdef SINGLE_STEP_EN
    step    = 1'b0;
`endif
    test_reset();
`ifdef SINGLE_STEP_EN
    test_single_step();
`else
    test_lda();
    test_sto_stall();
    test_skz_jmp();
    test_timeout();
    test_hlt();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
